// File: rtl/bird_launch_scheduler.sv
// Launch sequencer for the bird datapath: magazine, launch power, fire handshake to bird_move.
// Optional macro BIRD_LAUNCH_TIMEOUT_EN: abandon a launch that bird_move never acknowledges.
module bird_launch_scheduler #(
  parameter int NUM_BIRDS             = 5,
  parameter int MIN_SPEED             = 2,
  parameter int MAX_SPEED             = 40,
  parameter int SPEED_STEP            = 2,
  parameter int COOLDOWN_FRAMES       = 15,
  parameter int LAUNCH_TIMEOUT_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        key_fire,
  input  logic        key_power_up,
  input  logic        key_power_down,
  input  logic        enroll,
  output logic        fire_the_bird,
  output logic [10:0] initialX_speed,
  output logic        DR,
  output logic [3:0]  birds_left,
  output logic        game_over
);

  localparam int CNT_MAX = (COOLDOWN_FRAMES > LAUNCH_TIMEOUT_FRAMES) ? COOLDOWN_FRAMES
                                                                     : LAUNCH_TIMEOUT_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_RELOAD,
    S_AIM,
    S_LAUNCH,
    S_FLIGHT,
    S_COOLDOWN,
    S_GAME_OVER
  } state_t;

  state_t             state_q, state_d;
  logic               fire_prev_q, fire_prev_d;
  logic               fire_q, fire_d;
  logic [10:0]        speed_q, speed_d;
  logic [3:0]         birds_q, birds_d;
  logic               game_over_q, game_over_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic               fire_rise;
  logic [11:0]        spd_up, spd_dn;
  logic [10:0]        spd_up_sat, spd_dn_sat;
  logic [CNT_W-1:0]   cnt_inc;

  assign fire_rise = key_fire & ~fire_prev_q;
  assign cnt_inc   = frame_cnt_q + CNT_W'(1);

  // 12-bit headroom so the step cannot wrap before saturation is decided
  always_comb begin
    spd_up     = {1'b0, speed_q} + 12'(SPEED_STEP);
    spd_dn     = {1'b0, speed_q} - 12'(SPEED_STEP);
    spd_up_sat = (spd_up > 12'(MAX_SPEED)) ? 11'(MAX_SPEED) : spd_up[10:0];
    spd_dn_sat = (({1'b0, speed_q} < 12'(SPEED_STEP)) || (spd_dn < 12'(MIN_SPEED)))
                 ? 11'(MIN_SPEED) : spd_dn[10:0];
  end

  always_comb begin
    state_d     = state_q;
    fire_prev_d = key_fire;
    fire_d      = fire_q;
    speed_d     = speed_q;
    birds_d     = birds_q;
    game_over_d = game_over_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      S_RELOAD: begin
        birds_d     = 4'(NUM_BIRDS);
        speed_d     = 11'(MIN_SPEED);
        game_over_d = 1'b0;
        state_d     = S_AIM;
      end

      S_AIM: begin
        if (startOfFrame && (key_power_up != key_power_down))
          speed_d = key_power_up ? spd_up_sat : spd_dn_sat;
        if (fire_rise && (birds_q != 4'd0)) begin
          state_d     = S_LAUNCH;
          fire_d      = 1'b1;
          frame_cnt_d = '0;
        end
      end

      S_LAUNCH: begin
        if (enroll) begin
          state_d = S_FLIGHT;
          fire_d  = 1'b0;
          if (birds_q != 4'd0) birds_d = birds_q - 4'd1;
        end
`ifdef BIRD_LAUNCH_TIMEOUT_EN
        else if (startOfFrame) begin
          frame_cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(LAUNCH_TIMEOUT_FRAMES)) begin
            state_d = S_AIM;
            fire_d  = 1'b0;
          end
        end
`endif
      end

      S_FLIGHT: begin
        if (!enroll) begin
          state_d     = S_COOLDOWN;
          frame_cnt_d = '0;
        end
      end

      S_COOLDOWN: begin
        if (startOfFrame) begin
          frame_cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(COOLDOWN_FRAMES)) begin
            if (birds_q != 4'd0) begin
              state_d = S_AIM;
            end else begin
              state_d     = S_GAME_OVER;
              game_over_d = 1'b1;
            end
          end
        end
      end

      S_GAME_OVER: begin
        if (fire_rise) state_d = S_RELOAD;
      end

      default: state_d = S_RELOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RELOAD;
      fire_prev_q <= 1'b0;
      fire_q      <= 1'b0;
      speed_q     <= 11'(MIN_SPEED);
      birds_q     <= 4'(NUM_BIRDS);
      game_over_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fire_prev_q <= fire_prev_d;
      fire_q      <= fire_d;
      speed_q     <= speed_d;
      birds_q     <= birds_d;
      game_over_q <= game_over_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign fire_the_bird  = fire_q;
  assign initialX_speed = speed_q;
  assign birds_left     = birds_q;
  assign game_over      = game_over_q;
  assign DR             = (state_q == S_LAUNCH) || (state_q == S_FLIGHT);

endmodule

// File: tb/tb_bird_launch_scheduler.sv
// Scoreboard bench for bird_launch_scheduler: directed game sequences plus random keys,
// each cycle checked against a phase-level reference model.
module tb_bird_launch_scheduler;
  localparam int NB = 5, MINS = 2, MAXS = 40, STEP = 2, CD = 15, TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1, startOfFrame = 1'b0, key_fire = 1'b0;
  logic        key_power_up = 1'b0, key_power_down = 1'b0, enroll = 1'b0;
  logic        fire_the_bird, DR, game_over;
  logic [10:0] initialX_speed;
  logic [3:0]  birds_left;

  bird_launch_scheduler #(
    .NUM_BIRDS(NB), .MIN_SPEED(MINS), .MAX_SPEED(MAXS), .SPEED_STEP(STEP),
    .COOLDOWN_FRAMES(CD), .LAUNCH_TIMEOUT_FRAMES(TO)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .key_fire(key_fire),
    .key_power_up(key_power_up), .key_power_down(key_power_down), .enroll(enroll),
    .fire_the_bird(fire_the_bird), .initialX_speed(initialX_speed), .DR(DR),
    .birds_left(birds_left), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct { int fire; int spd; int dr; int birds; int go; } exp_t;
  exp_t exp_q[$];
  int checks = 0, failures = 0;

  // Reference model: game phase plus plain integer bookkeeping
  typedef enum {M_RELOAD, M_AIM, M_LAUNCH, M_FLIGHT, M_COOLDOWN, M_OVER} phase_t;
  phase_t m_ph = M_RELOAD;
  int m_spd = MINS, m_birds = NB, m_frames = 0;
  bit m_fire = 0, m_go = 0, m_prev = 0;

  function automatic void model_step(input bit r, input bit sof, input bit f,
                                     input bit up, input bit dn, input bit en);
    bit rise;
    rise   = f && !m_prev;
    m_prev = r ? 1'b0 : f;
    if (r) begin
      m_ph = M_RELOAD; m_spd = MINS; m_birds = NB; m_go = 0; m_fire = 0; m_frames = 0;
      return;
    end
    case (m_ph)
      M_RELOAD: begin m_birds = NB; m_spd = MINS; m_go = 0; m_ph = M_AIM; end
      M_AIM: begin
        if (sof && (up != dn)) begin
          if (up) m_spd = (m_spd + STEP > MAXS) ? MAXS : m_spd + STEP;
          else    m_spd = (m_spd - STEP < MINS) ? MINS : m_spd - STEP;
        end
        if (rise && m_birds > 0) begin m_ph = M_LAUNCH; m_fire = 1; m_frames = 0; end
      end
      M_LAUNCH: begin
        if (en) begin
          m_ph = M_FLIGHT; m_fire = 0;
          if (m_birds > 0) m_birds = m_birds - 1;
        end
`ifdef BIRD_LAUNCH_TIMEOUT_EN
        else if (sof) begin
          m_frames++;
          if (m_frames == TO) begin m_ph = M_AIM; m_fire = 0; end
        end
`endif
      end
      M_FLIGHT: if (!en) begin m_ph = M_COOLDOWN; m_frames = 0; end
      M_COOLDOWN: if (sof) begin
        m_frames++;
        if (m_frames == CD) begin
          if (m_birds > 0) m_ph = M_AIM;
          else begin m_ph = M_OVER; m_go = 1; end
        end
      end
      M_OVER: if (rise) m_ph = M_RELOAD;
      default: m_ph = M_RELOAD;
    endcase
  endfunction

  // Stimulus state; bm_* emulate bird_move acknowledging a launch
  bit s_fire = 0, s_up = 0, s_dn = 0, s_bird = 1;
  int bm_wait = 0, bm_fly = 0;

  task automatic cyc(input bit r, input bit sof, input bit en);
    reset = r; startOfFrame = sof; key_fire = s_fire;
    key_power_up = s_up; key_power_down = s_dn; enroll = en;
    @(posedge clk);
    model_step(r, sof, s_fire, s_up, s_dn, en);
    exp_q.push_back('{int'(m_fire), m_spd,
                      int'(m_ph == M_LAUNCH || m_ph == M_FLIGHT), m_birds, int'(m_go)});
    #1;
  endtask

  task automatic tick_sof(input bit sof);
    bit en;
    en = 0;
    if (!s_bird) begin
      bm_wait = 0; bm_fly = 0;
    end else if (bm_fly > 0) begin
      en = 1; bm_fly--;
    end else if (m_fire) begin
      bm_wait++;
      if (bm_wait > 2) begin en = 1; bm_wait = 0; bm_fly = $urandom_range(2, 10); end
    end else begin
      bm_wait = 0;
    end
    cyc(1'b0, sof, en);
  endtask

  task automatic do_reset(input int n);
    bm_wait = 0; bm_fly = 0;
    repeat (n) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick_sof(1'b0);
  endtask

  task automatic frames(input int n);
    repeat (n) begin tick_sof(1'b1); tick_sof(1'b0); tick_sof(1'b0); end
  endtask

  task automatic press();
    s_fire = 1; tick_sof(1'b0);
    s_fire = 0; tick_sof(1'b0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fire_the_bird",  int'(fire_the_bird),  e.fire);
        chk("initialX_speed", int'(initialX_speed), e.spd);
        chk("DR",             int'(DR),             e.dr);
        chk("birds_left",     int'(birds_left),     e.birds);
        chk("game_over",      int'(game_over),      e.go);
      end
    end
  end

  initial begin
    do_reset(2);
    idle(2);
    // power ramp, saturation, both keys held
    s_up = 1; frames(3);
    frames(30);
    s_dn = 1; frames(2);
    s_up = 0; frames(2);
    s_dn = 0;
    // five full birds, key_fire pressed during the first cooldown
    for (int b = 0; b < NB; b++) begin
      press();
      idle(20);
      frames(5);
      if (b == 0) press();
      frames(11);
    end
    idle(3);
    press();
    idle(4);
    // launch never acknowledged
    s_bird = 0;
    press();
    frames(10);
    s_bird = 1;
    idle(20);
    frames(16);
    // reset while the bird is in flight
    press();
    idle(3);
    do_reset(1);
    idle(4);
    // random play
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) s_fire = ~s_fire;
      if ($urandom_range(0, 2) == 0) s_up = $urandom_range(0, 1);
      if ($urandom_range(0, 2) == 0) s_dn = $urandom_range(0, 1);
      if (i % 100 == 0) s_bird = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 399) == 0) do_reset(1);
      else tick_sof($urandom_range(0, 2) == 0);
    end
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bird_launch_scheduler.md
# bird_launch_scheduler

Sequences the bird trajectory generator: owns the bird magazine, the launch-power setting and the fire handshake toward `bird_move`. Takes player keys plus frame tick, drives `fire_the_bird` and `initialX_speed`, and watches `enroll` to know when a bird is in flight. Sits between the key interface and the bird datapath; also exports `DR` (bird on screen) and a game-over flag to the top-level game logic.

## Interface
Parameters:
- NUM_BIRDS, 5, birds per round (1..15)
- MIN_SPEED, 2, lowest launch X speed
- MAX_SPEED, 40, highest launch X speed
- SPEED_STEP, 2, power change per frame while a power key is held
- COOLDOWN_FRAMES, 15, frames between bird landing and next aim
- LAUNCH_TIMEOUT_FRAMES, 4, frames to wait for `enroll` after firing

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per frame
- key_fire  in  1  fire key level
- key_power_up  in  1  power-up key level
- key_power_down  in  1  power-down key level
- enroll  in  1  from `bird_move`: bird in flight
- fire_the_bird  out  1  launch request level to `bird_move`
- initialX_speed  out  11  current launch power (unsigned)
- DR  out  1  bird on screen (launch pending or in flight)
- birds_left  out  4  birds remaining in magazine
- game_over  out  1  magazine empty and last bird finished

## Operation
- Fire edge: internal `fire_prev` registered each cycle; `fire_rise = key_fire & ~fire_prev`.
- States: RELOAD, AIM, LAUNCH, FLIGHT, COOLDOWN, GAME_OVER.
- RELOAD (entered from reset): `birds_left<=NUM_BIRDS`, `initialX_speed<=MIN_SPEED`, `game_over<=0`; next cycle -> AIM.
- AIM: on `startOfFrame`, exactly one power key held -> add/subtract SPEED_STEP, saturating at MAX_SPEED/MIN_SPEED; both or neither held -> no change. `fire_rise` with `birds_left>0` -> LAUNCH, `fire_the_bird<=1`, frame counter cleared.
- LAUNCH: `fire_the_bird` held 1; `initialX_speed` frozen. `enroll==1` -> FLIGHT, `fire_the_bird<=0`, `birds_left<=birds_left-1`.
- FLIGHT: power keys ignored. `enroll==0` -> COOLDOWN, frame counter cleared.
- COOLDOWN: count `startOfFrame` pulses; at COOLDOWN_FRAMES -> AIM if `birds_left>0`, else GAME_OVER with `game_over<=1`.
- GAME_OVER: `fire_rise` -> RELOAD. Power keys ignored.
- `DR = 1` in LAUNCH and FLIGHT, else 0 (combinational from state).
- `birds_left` never decrements below 0; decrement happens only on the LAUNCH->FLIGHT transition.
- `initialX_speed` arithmetic done in 12 bits before saturation; parameters must satisfy MIN_SPEED<=MAX_SPEED<=2047.

## Timing
- Reset values: `fire_the_bird=0`, `initialX_speed=MIN_SPEED`, `DR=0`, `birds_left=NUM_BIRDS`, `game_over=0`, state RELOAD, `fire_prev=0`.
- `key_fire` rising at cycle N (sampled) -> `fire_rise` at N -> `fire_the_bird=1` at N+1.
- `fire_the_bird` stays high until the cycle after `enroll` is sampled high (level handshake; `bird_move` edge-detects it internally).
- Power update visible the cycle after the `startOfFrame` pulse; at most one step per frame.
- COOLDOWN exit on the cycle after the COOLDOWN_FRAMES-th `startOfFrame` pulse.
- `key_fire` held continuously fires only once; a new press needs a low sample first.
- `startOfFrame` coincident with `fire_rise` in AIM: power step applied and LAUNCH entered in the same cycle; frozen value is the stepped one.
- Reset asserted in any state: all outputs take reset values next edge; `fire_the_bird` drops immediately, in-flight bird is abandoned (bird_move resets independently).

## Configuration
- `BIRD_LAUNCH_TIMEOUT_EN` defined: in LAUNCH, count `startOfFrame`; reaching LAUNCH_TIMEOUT_FRAMES with `enroll` still 0 -> `fire_the_bird<=0`, back to AIM, `birds_left` unchanged.
- Not defined: LAUNCH waits indefinitely for `enroll`; LAUNCH_TIMEOUT_FRAMES unused.

## Test plan
- Reset, then 3 frames with `key_power_up` held -> `initialX_speed` 2->4->6->8; 30 frames more -> saturates at 40; both keys held 2 frames -> stays 40.
- AIM, pulse `key_fire`; model `enroll` rising 2 cycles after `fire_the_bird` -> `fire_the_bird` high 3 cycles, `DR` high, `birds_left` 5->4.
- Drop `enroll` -> COOLDOWN; exactly 15 `startOfFrame` pulses later state AIM; `key_fire` during cooldown ignored (no `fire_the_bird`).
- Fire 5 birds through full cycles -> after 5th cooldown `game_over=1`, `birds_left=0`; `key_fire` rise -> next cycle RELOAD, then `birds_left=5`, `game_over=0`, `initialX_speed=2`.
- With `BIRD_LAUNCH_TIMEOUT_EN`, fire with `enroll` tied 0 -> after 4 frames `fire_the_bird=0`, AIM, `birds_left` unchanged; without macro -> `fire_the_bird` still 1 after 10 frames.
- Assert `reset` mid-FLIGHT -> next edge all outputs at reset values, `DR=0`.
